// File: rtl/k2_loader_pkg.sv
// k2_loader_pkg: shared types and constants for the K2 writable program store.
//   loader_state_t : loader FSM state (LOAD, RUN)
//   K2_ADDR_BITS   : default program address width
//   K2_INST_BITS   : default instruction width
//   K2_DEPTH       : number of program words at the default address width
//   K2_NOP         : value returned for addresses never written in this program
package k2_loader_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

  localparam int K2_ADDR_BITS = 4;
  localparam int K2_INST_BITS = 8;
  localparam int K2_DEPTH     = 1 << K2_ADDR_BITS;

  localparam logic [7:0] K2_NOP = 8'h00;

endpackage

// File: rtl/k2_loader_mem.sv
// k2_loader_mem: program word array with a per-entry valid bit.
//   clk        in  clock
//   we         in  write enable; stores wdata at waddr and marks it valid
//   waddr      in  write address
//   wdata      in  write data
//   clr_valid  in  synchronous clear of every valid bit (data is kept)
//   raddr      in  combinational read address
//   rdata      out word at raddr
//   rvalid     out valid bit at raddr
// Data words carry no reset; the valid bits decide whether a word is visible.
module k2_loader_mem #(
  parameter int AddrBits = 4,
  parameter int InstBits = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AddrBits-1:0] waddr,
  input  logic [InstBits-1:0] wdata,
  input  logic                clr_valid,
  input  logic [AddrBits-1:0] raddr,
  output logic [InstBits-1:0] rdata,
  output logic                rvalid
);

  localparam int Depth = 1 << AddrBits;

  logic [InstBits-1:0] mem_q [Depth];
  logic [Depth-1:0]    valid_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Clear wins over a simultaneous write so a reset can never leave a stale entry visible.
  always_ff @(posedge clk) begin
    if (clr_valid) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem_q[raddr];
  assign rvalid = valid_q[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// k2_program_loader: writable program store replacing the K2 program ROM.
//   clk, rst          clock and synchronous active-high reset
//   load_valid/ready  byte handshake; load_data is the byte, load_last ends the program
//   reload            request (in RUN) to discard the program and load again
//   ProgramAddress    processor fetch address
//   instruction_data  combinational fetch data (NOP for unwritten words or while loading)
//   core_rst_n        active-low processor reset, released in RUN
//   loaded            high in RUN
//   prog_len          bytes accepted in the current program
//   load_error        sticky: a byte was offered while in RUN
//
// state | meaning
// LOAD  | accepting bytes, processor held in reset
// RUN   | program loaded, processor running, writes refused
module k2_program_loader
  import k2_loader_pkg::*;
#(
  parameter int AddrBits = K2_ADDR_BITS,
  parameter int InstBits = K2_INST_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic [InstBits-1:0] load_data,
  input  logic                load_last,
  output logic                load_ready,
  input  logic                reload,
  input  logic [AddrBits-1:0] ProgramAddress,
  output logic [InstBits-1:0] instruction_data,
  output logic                core_rst_n,
  output logic                loaded,
  output logic [AddrBits:0]   prog_len,
  output logic                load_error
);

  localparam logic [AddrBits-1:0] LastAddr = '1;
  localparam logic [AddrBits-1:0] PtrOne   = AddrBits'(1);
  localparam logic [AddrBits:0]   LenOne   = (AddrBits + 1)'(1);

  loader_state_t       state_q, state_d;
  logic [AddrBits-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrBits:0]   prog_len_q, prog_len_d;
  logic                load_error_q, load_error_d;
  logic                accept;
  logic                clr_valid;
  logic [InstBits-1:0] rd_data;
  logic                rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      load_error_q <= load_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    load_error_d = load_error_q;
    accept       = 1'b0;
    clr_valid    = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (load_valid) begin
          accept     = 1'b1;
          prog_len_d = prog_len_q + LenOne;
          // Pointer saturates at the last word; the full condition forces RUN anyway.
          if (wr_ptr_q != LastAddr) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
          end
          if (load_last || (wr_ptr_q == LastAddr)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // reload takes priority so a byte offered alongside it is not flagged.
        if (reload) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          prog_len_d   = '0;
          load_error_d = 1'b0;
          clr_valid    = 1'b1;
        end else if (load_valid) begin
          load_error_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  k2_loader_mem #(
    .AddrBits(AddrBits),
    .InstBits(InstBits)
  ) u_mem (
    .clk       (clk),
    .we        (accept & ~rst),
    .waddr     (wr_ptr_q),
    .wdata     (load_data),
    .clr_valid (clr_valid | rst),
    .raddr     (ProgramAddress),
    .rdata     (rd_data),
    .rvalid    (rd_valid)
  );

  assign load_ready       = (state_q == LOAD);
  assign core_rst_n       = (state_q == RUN);
  assign loaded           = (state_q == RUN);
  assign prog_len         = prog_len_q;
  assign load_error       = load_error_q;
  assign instruction_data = ((state_q == RUN) && rd_valid) ? rd_data : InstBits'(K2_NOP);

endmodule

// File: tb/tb_k2_program_loader.sv
`timescale 1ns/1ps
module tb_k2_program_loader;
  import k2_loader_pkg::*;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       reload;
  logic [3:0] ProgramAddress;
  logic [7:0] instruction_data;
  logic       core_rst_n;
  logic       loaded;
  logic [4:0] prog_len;
  logic       load_error;

  int n_cmp;
  int n_fail;

  k2_program_loader #(.AddrBits(4), .InstBits(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_last        (load_last),
    .load_ready       (load_ready),
    .reload           (reload),
    .ProgramAddress   (ProgramAddress),
    .instruction_data (instruction_data),
    .core_rst_n       (core_rst_n),
    .loaded           (loaded),
    .prog_len         (prog_len),
    .load_error       (load_error)
  );

  // Long period leaves room for several #1 address sweeps between edges.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    n_cmp++; if (core_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
    n_cmp++; if (loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    n_cmp++; if (prog_len !== 5'd0) begin n_fail++; $display("FAIL reset_prog_len: got %0d want 0", prog_len); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_load_error: got %b want 0", load_error); end
    for (int a = 0; a < K2_DEPTH; a++) begin
      ProgramAddress = 4'(a);
      #1;
      n_cmp++; if (instruction_data !== 8'h00) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want 00", a, instruction_data); end
    end
  endtask

  task automatic test_short_program();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h00;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    n_cmp++; if (core_rst_n !== 1'b0) begin n_fail++; $display("FAIL short_hold_rst: got %b want 0", core_rst_n); end
    n_cmp++; if (prog_len !== 5'd2) begin n_fail++; $display("FAIL short_len_mid: got %0d want 2", prog_len); end
    send_byte(8'h33, 1'b1);
    n_cmp++; if (core_rst_n !== 1'b1) begin n_fail++; $display("FAIL short_release: got %b want 1", core_rst_n); end
    n_cmp++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL short_loaded: got %b want 1", loaded); end
    n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL short_ready: got %b want 0", load_ready); end
    n_cmp++; if (prog_len !== 5'd3) begin n_fail++; $display("FAIL short_len: got %0d want 3", prog_len); end
    for (int a = 0; a < 4; a++) begin
      ProgramAddress = 4'(a);
      #1;
      n_cmp++; if (instruction_data !== exp_rd[a]) begin n_fail++; $display("FAIL short_read[%0d]: got %h want %h", a, instruction_data, exp_rd[a]); end
    end
  endtask

  task automatic test_full_memory();
    pulse_reload();
    n_cmp++; if (core_rst_n !== 1'b0) begin n_fail++; $display("FAIL full_reload_rst: got %b want 0", core_rst_n); end
    n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL full_reload_ready: got %b want 1", load_ready); end
    n_cmp++; if (prog_len !== 5'd0) begin n_fail++; $display("FAIL full_reload_len: got %0d want 0", prog_len); end
    for (int i = 0; i < 15; i++) send_byte(8'h80 + 8'(i), 1'b0);
    n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL full_after15_ready: got %b want 1", load_ready); end
    n_cmp++; if (prog_len !== 5'd15) begin n_fail++; $display("FAIL full_after15_len: got %0d want 15", prog_len); end
    send_byte(8'h8F, 1'b0);
    n_cmp++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL full_loaded: got %b want 1", loaded); end
    n_cmp++; if (prog_len !== 5'd16) begin n_fail++; $display("FAIL full_len: got %0d want 16", prog_len); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL full_err_before: got %b want 0", load_error); end
    load_valid = 1'b1;
    load_data  = 8'hEE;
    #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_17th_ready: got %b want 0", load_ready); end
    step();
    load_valid = 1'b0;
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL full_17th_error: got %b want 1", load_error); end
    n_cmp++; if (prog_len !== 5'd16) begin n_fail++; $display("FAIL full_17th_len: got %0d want 16", prog_len); end
    ProgramAddress = 4'd15;
    #1;
    n_cmp++; if (instruction_data !== 8'h8F) begin n_fail++; $display("FAIL full_read15: got %h want 8f", instruction_data); end
    ProgramAddress = 4'd0;
    #1;
    n_cmp++; if (instruction_data !== 8'h80) begin n_fail++; $display("FAIL full_read0: got %h want 80", instruction_data); end
    ProgramAddress = 4'd7;
    #1;
    n_cmp++; if (instruction_data !== 8'h87) begin n_fail++; $display("FAIL full_read7: got %h want 87", instruction_data); end
  endtask

  task automatic test_bursty();
    pulse_reload();
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL bursty_err_cleared: got %b want 0", load_error); end
    load_valid = 1'b1; load_data = 8'hA0; load_last = 1'b0;
    step();
    load_valid = 1'b0; load_data = 8'hFF;
    step();
    n_cmp++; if (prog_len !== 5'd1) begin n_fail++; $display("FAIL bursty_gap_len: got %0d want 1", prog_len); end
    load_valid = 1'b1; load_data = 8'hA1; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0; load_data = 8'hFF;
    step();
    n_cmp++; if (prog_len !== 5'd2) begin n_fail++; $display("FAIL bursty_len: got %0d want 2", prog_len); end
    n_cmp++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL bursty_loaded: got %b want 1", loaded); end
    ProgramAddress = 4'd0;
    #1;
    n_cmp++; if (instruction_data !== 8'hA0) begin n_fail++; $display("FAIL bursty_read0: got %h want a0", instruction_data); end
    ProgramAddress = 4'd1;
    #1;
    n_cmp++; if (instruction_data !== 8'hA1) begin n_fail++; $display("FAIL bursty_read1: got %h want a1", instruction_data); end
    // Address 2 still holds 0x82 from the full load but its valid bit was cleared.
    ProgramAddress = 4'd2;
    #1;
    n_cmp++; if (instruction_data !== 8'h00) begin n_fail++; $display("FAIL bursty_read2: got %h want 00", instruction_data); end
  endtask

  task automatic test_reload_collision();
    load_valid = 1'b1; load_data = 8'h99;
    step();
    load_valid = 1'b0;
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL coll_err_set: got %b want 1", load_error); end
    reload = 1'b1; load_valid = 1'b1; load_data = 8'h55; load_last = 1'b1;
    step();
    reload = 1'b0;
    n_cmp++; if (core_rst_n !== 1'b0) begin n_fail++; $display("FAIL coll_core_rst_n: got %b want 0", core_rst_n); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL coll_err: got %b want 0", load_error); end
    n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready: got %b want 1", load_ready); end
    n_cmp++; if (prog_len !== 5'd0) begin n_fail++; $display("FAIL coll_len: got %0d want 0", prog_len); end
    for (int a = 0; a < K2_DEPTH; a++) begin
      ProgramAddress = 4'(a);
      #1;
      n_cmp++; if (instruction_data !== 8'h00) begin n_fail++; $display("FAIL coll_read[%0d]: got %h want 00", a, instruction_data); end
    end
    step();
    load_valid = 1'b0; load_last = 1'b0;
    n_cmp++; if (prog_len !== 5'd1) begin n_fail++; $display("FAIL coll_accept_len: got %0d want 1", prog_len); end
    n_cmp++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL coll_accept_loaded: got %b want 1", loaded); end
    ProgramAddress = 4'd0;
    #1;
    n_cmp++; if (instruction_data !== 8'h55) begin n_fail++; $display("FAIL coll_read0: got %h want 55", instruction_data); end
    ProgramAddress = 4'd1;
    #1;
    n_cmp++; if (instruction_data !== 8'h00) begin n_fail++; $display("FAIL coll_read1: got %h want 00", instruction_data); end
  endtask

  task automatic test_reset_mid_load();
    pulse_reload();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    n_cmp++; if (prog_len !== 5'd2) begin n_fail++; $display("FAIL midrst_len_before: got %0d want 2", prog_len); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (prog_len !== 5'd0) begin n_fail++; $display("FAIL midrst_len: got %0d want 0", prog_len); end
    n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", load_ready); end
    send_byte(8'h77, 1'b1);
    n_cmp++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL midrst_loaded: got %b want 1", loaded); end
    n_cmp++; if (prog_len !== 5'd1) begin n_fail++; $display("FAIL midrst_len_after: got %0d want 1", prog_len); end
    ProgramAddress = 4'd0;
    #1;
    n_cmp++; if (instruction_data !== 8'h77) begin n_fail++; $display("FAIL midrst_read0: got %h want 77", instruction_data); end
    ProgramAddress = 4'd1;
    #1;
    n_cmp++; if (instruction_data !== 8'h00) begin n_fail++; $display("FAIL midrst_read1: got %h want 00", instruction_data); end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    load_valid     = 1'b0;
    load_data      = 8'h00;
    load_last      = 1'b0;
    reload         = 1'b0;
    ProgramAddress = 4'd0;
    test_reset();
    test_short_program();
    test_full_memory();
    test_bursty();
    test_reload_collision();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
